// File: rtl/mc_core.sv
// mc_core: multicycle RV32I-subset core (lw/sw/R/I ALU/beq/jal) with a single shared memory port.
// Define MC_ILLEGAL_TRAP_EN to halt on unsupported instructions; otherwise they retire as NOPs.
module mc_core #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [XLEN-1:0] pc,
  output logic            instr_retired,
  output logic            halted
);
  localparam int RW = $clog2(NREGS);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , HALT
`endif
  } state_t;

  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, data_q, data_d;
  logic [31:0] ir_q, ir_d;
  logic retired_q, retired_d;
  logic [XLEN-1:0] rf_q [NREGS];

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [RW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, rs1_v, rs2_v;
  logic [XLEN-1:0] alu_b, alu_res, rf_wd;
  logic alu_f3_ok, is_mem, is_r, is_i, is_beq, is_jal, legal, alu_sub, slt, rf_we;
  state_t target;

  assign opcode = ir_q[6:0];
  assign f3     = ir_q[14:12];
  assign f7     = ir_q[31:25];
  assign rs1    = ir_q[15 +: RW];
  assign rs2    = ir_q[20 +: RW];
  assign rd     = ir_q[7 +: RW];

  assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign rs1_v = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_v = (rs2 == '0) ? '0 : rf_q[rs2];

  assign alu_f3_ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  assign is_mem = (opcode == OP_LW || opcode == OP_SW) && f3 == 3'b010;
  assign is_r   = opcode == OP_R && alu_f3_ok && (f7 == 7'b0 || (f7 == 7'b0100000 && f3 == 3'b000));
  assign is_i   = opcode == OP_I && alu_f3_ok;
  assign is_beq = opcode == OP_BEQ && f3 == 3'b000;
  assign is_jal = opcode == OP_JAL;
  assign legal  = is_mem || is_r || is_i || is_beq || is_jal;
  assign target = is_mem ? MEMADR : is_r ? EXECR : is_i ? EXECI : is_beq ? BEQ : JAL;

  assign alu_b   = (state_q == EXECR) ? b_q : imm_i;
  assign alu_sub = state_q == EXECR && f7 == 7'b0100000;
  assign slt     = $signed(a_q) < $signed(alu_b);
  assign alu_res = (f3 == 3'b000) ? (alu_sub ? a_q - alu_b : a_q + alu_b) :
                   (f3 == 3'b010) ? {{(XLEN-1){1'b0}}, slt} :
                   (f3 == 3'b110) ? (a_q | alu_b) : (a_q & alu_b);

  assign rf_we = state_q == MEMWB || state_q == ALUWB || state_q == JAL;
  assign rf_wd = (state_q == MEMWB) ? data_q : (state_q == JAL) ? oldpc_q + XLEN'(4) : aluout_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    oldpc_d  = oldpc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    data_d   = data_q;
    case (state_q)
      FETCH: if (mem_ack) begin
        ir_d    = mem_rdata[31:0];
        oldpc_d = pc_q;
        pc_d    = pc_q + XLEN'(4);
        state_d = DECODE;
      end
      DECODE: begin
        a_d      = rs1_v;
        b_d      = rs2_v;
        aluout_d = oldpc_q + (is_jal ? imm_j : imm_b);
`ifdef MC_ILLEGAL_TRAP_EN
        state_d  = legal ? target : HALT;
        pc_d     = legal ? pc_q : oldpc_q;
`else
        state_d  = legal ? target : FETCH;
`endif
      end
      MEMADR: begin
        aluout_d = a_q + (opcode[5] ? imm_s : imm_i);
        state_d  = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: if (mem_ack) begin
        data_d  = mem_rdata;
        state_d = MEMWB;
      end
      MEMWRITE: state_d = mem_ack ? FETCH : MEMWRITE;
      EXECR, EXECI: begin
        aluout_d = alu_res;
        state_d  = ALUWB;
      end
      BEQ: begin
        pc_d    = (a_q == b_q) ? aluout_q : pc_q;
        state_d = FETCH;
      end
      JAL: begin
        pc_d    = aluout_q;
        state_d = FETCH;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      HALT: state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Retire is registered so the pulse lands in the first FETCH cycle after an instruction ends.
  assign retired_d = state_q != FETCH && state_d == FETCH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      oldpc_q   <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      data_q    <= '0;
      retired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      oldpc_q   <= oldpc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      aluout_q  <= aluout_d;
      data_q    <= data_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && rd != '0) rf_q[rd] <= rf_wd;
  end

  // Gating with rst_n drops an in-flight request the moment reset asserts.
  assign mem_req       = rst_n && (state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE);
  assign mem_we        = state_q == MEMWRITE;
  assign mem_addr      = (state_q == FETCH) ? pc_q : aluout_q;
  assign mem_wdata     = b_q;
  assign pc            = pc_q;
  assign instr_retired = retired_q;
`ifdef MC_ILLEGAL_TRAP_EN
  assign halted = state_q == HALT;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: scoreboard bench for mc_core; memory trace and retire events checked against hand-computed queues.
module tb_mc_core;
  localparam logic [6:0] OP_I = 7'b0010011, OP_L = 7'b0000011;

  logic clk = 0, rst_n = 1, mem_ack = 0;
  logic mem_req, mem_we, instr_retired, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, pc;

  mc_core dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
    .instr_retired(instr_retired), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int dly; } mx_t;
  typedef struct { logic [31:0] pc; int lat; } rx_t;
  mx_t exp_m[$];
  rx_t exp_r[$];
  logic [31:0] mem [256];
  int tests = 0, fails = 0, cyc = 0, last_ret = 0, wc = 0, fd = 0, waits = 0;
  logic busy = 0, s_we;
  logic [31:0] s_addr, s_wd;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ei(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] er(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] es(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] eb(logic [12:0] imm, logic [4:0] rs1, logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] ej(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Load an instruction and expect its fetch plus its retire (next pc, latency in cycles).
  task automatic ins(logic [31:0] a, logic [31:0] w, logic [31:0] npc, int lat);
    mem[a[9:2]] = w;
    exp_m.push_back('{1'b0, a, 32'h0, fd});
    exp_r.push_back('{npc, lat});
  endtask
  task automatic dat(logic we, logic [31:0] a, logic [31:0] wd, int d);
    exp_m.push_back('{we, a, wd, d});
  endtask

  task automatic start_seg(int fdel);
    rst_n = 0;
    #1;
    exp_m.delete();
    exp_r.delete();
    foreach (mem[i]) mem[i] = 32'h0;
    fd = fdel;
  endtask
  task automatic go();
    @(posedge clk);
    #2 rst_n = 1;
  endtask
  task automatic drain(string name, int budget);
    int n = 0;
    while ((exp_m.size() > 0 || exp_r.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_pending"}, exp_m.size() + exp_r.size(), 0);
    #3;
  endtask

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // Memory responder: ack latency comes from the transaction at the head of the expected queue.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 0;
      wc = 0;
    end else begin
      if (mem_ack) wc = 0;
      if (wc >= (exp_m.size() > 0 ? exp_m[0].dly : 0)) begin
        mem_ack = 1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
      end else begin
        mem_ack = 0;
        wc++;
      end
    end
  end

  always begin
    mx_t e;
    rx_t r;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      busy = 0;
      last_ret = 0;
    end else begin
      if (mem_req && !busy) begin
        busy = 1;
        waits = 0;
        s_we = mem_we;
        s_addr = mem_addr;
        s_wd = mem_wdata;
      end
      if (mem_req && mem_ack) begin
        busy = 0;
        if (exp_m.size() > 0) begin
          e = exp_m.pop_front();
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          if (waits > 0) begin
            chk("stable_addr", mem_addr, s_addr);
            chk("stable_we", {31'b0, mem_we}, {31'b0, s_we});
            if (e.we) chk("stable_wdata", mem_wdata, s_wd);
          end
        end
      end else if (mem_req) waits++;
      else busy = 0;
      if (instr_retired) begin
        if (exp_r.size() > 0) begin
          r = exp_r.pop_front();
          chk("retire_pc", pc, r.pc);
          chk("retire_lat", cyc - last_ret, r.lat);
        end
        last_ret = cyc;
      end
    end
  end

  initial begin
    #1;
    // ALU, sign extension and x0 discard, zero-wait memory
    start_seg(0);
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retired", {31'b0, instr_retired}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    ins(32'h00, ei(12'd5, 0, 0, 1, OP_I), 32'h04, 4);
    ins(32'h04, es(12'h080, 1, 0), 32'h08, 4); dat(1, 32'h80, 32'd5, 0);
    ins(32'h08, ei(12'hFFD, 0, 0, 1, OP_I), 32'h0C, 4);
    ins(32'h0C, ei(12'd2, 0, 0, 2, OP_I), 32'h10, 4);
    ins(32'h10, er(7'h00, 2, 1, 0, 3), 32'h14, 4);
    ins(32'h14, es(12'h084, 3, 0), 32'h18, 4); dat(1, 32'h84, 32'hFFFFFFFF, 0);
    ins(32'h18, er(7'h20, 2, 1, 0, 3), 32'h1C, 4);
    ins(32'h1C, es(12'h088, 3, 0), 32'h20, 4); dat(1, 32'h88, 32'hFFFFFFFB, 0);
    ins(32'h20, er(7'h00, 2, 1, 2, 3), 32'h24, 4);
    ins(32'h24, es(12'h08C, 3, 0), 32'h28, 4); dat(1, 32'h8C, 32'h1, 0);
    ins(32'h28, er(7'h00, 2, 1, 6, 3), 32'h2C, 4);
    ins(32'h2C, es(12'h090, 3, 0), 32'h30, 4); dat(1, 32'h90, 32'hFFFFFFFF, 0);
    ins(32'h30, er(7'h00, 2, 1, 7, 3), 32'h34, 4);
    ins(32'h34, es(12'h094, 3, 0), 32'h38, 4); dat(1, 32'h94, 32'h0, 0);
    ins(32'h38, ei(12'd7, 0, 0, 0, OP_I), 32'h3C, 4);
    ins(32'h3C, es(12'h098, 0, 0), 32'h40, 4); dat(1, 32'h98, 32'h0, 0);
    ins(32'h40, ei(12'd0, 1, 2, 4, OP_I), 32'h44, 4);
    ins(32'h44, es(12'h09C, 4, 0), 32'h48, 4); dat(1, 32'h9C, 32'h1, 0);
    ins(32'h48, ei(12'hFF0, 1, 7, 5, OP_I), 32'h4C, 4);
    ins(32'h4C, es(12'h0A0, 5, 0), 32'h50, 4); dat(1, 32'h A0, 32'hFFFFFFF0, 0);
    go();
    drain("alu", 300);
    // store/load with three wait cycles on data accesses
    start_seg(0);
    ins(32'h00, ej(21'h40, 0), 32'h40, 3);
    ins(32'h40, ei(12'h123, 0, 0, 1, OP_I), 32'h44, 4);
    ins(32'h44, es(12'd8, 1, 0), 32'h48, 7); dat(1, 32'h08, 32'h123, 3);
    ins(32'h48, ei(12'd8, 0, 2, 4, OP_L), 32'h4C, 8); dat(0, 32'h08, 32'h0, 3);
    ins(32'h4C, es(12'h080, 4, 0), 32'h50, 4); dat(1, 32'h80, 32'h123, 0);
    go();
    drain("ldst", 200);
    // branches and jumps with one fetch wait cycle
    start_seg(1);
    ins(32'h00, ej(21'h10, 0), 32'h10, 4);
    ins(32'h10, eb(13'h1FFC, 0, 0), 32'h0C, 4);
    ins(32'h0C, ej(21'h14, 0), 32'h20, 4);
    ins(32'h20, ej(21'h10, 1), 32'h30, 4);
    ins(32'h30, es(12'h080, 1, 0), 32'h34, 5); dat(1, 32'h80, 32'h24, 0);
    ins(32'h34, eb(13'd8, 1, 0), 32'h38, 4);
    ins(32'h38, eb(13'd8, 0, 0), 32'h40, 4);
    ins(32'h40, es(12'h084, 1, 0), 32'h44, 5); dat(1, 32'h84, 32'h24, 0);
    go();
    drain("branch", 200);
    // reset asserted while a fetch is waiting for ack
    start_seg(5);
    mem[0] = ei(12'd1, 0, 0, 1, OP_I);
    dat(0, 32'h0, 32'h0, 5);
    go();
    repeat (2) @(negedge clk);
    #2;
    chk("wait_req", {31'b0, mem_req}, 1);
    chk("wait_ack", {31'b0, mem_ack}, 0);
    rst_n = 0;
    #1;
    chk("midrst_req", {31'b0, mem_req}, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_retired", {31'b0, instr_retired}, 0);
    // unsupported opcode 0x7F
    start_seg(0);
`ifdef MC_ILLEGAL_TRAP_EN
    mem[0] = 32'h0000007F;
    dat(0, 32'h0, 32'h0, 0);
    go();
    drain("illegal", 50);
    repeat (6) @(negedge clk);
    #2;
    chk("halt_halted", {31'b0, halted}, 1);
    chk("halt_req", {31'b0, mem_req}, 0);
    chk("halt_pc", pc, 0);
    chk("halt_retired", {31'b0, instr_retired}, 0);
`else
    ins(32'h00, 32'h0000007F, 32'h04, 2);
    ins(32'h04, ei(12'd9, 0, 0, 1, OP_I), 32'h08, 4);
    ins(32'h08, es(12'h080, 1, 0), 32'h0C, 4); dat(1, 32'h80, 32'd9, 0);
    go();
    drain("illegal", 100);
    chk("nop_halted", {31'b0, halted}, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address/PC width; legal values 32 or 64.
REQ-002 SHALL have parameter NREGS, default 32, register count; legal 16 or 32; register index uses low log2(NREGS) bits.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_req  output  1  memory request, held until acknowledged.
REQ-007 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req.
REQ-008 SHALL have port mem_addr  output  XLEN  byte address; valid while mem_req.
REQ-009 SHALL have port mem_wdata  output  XLEN  store data; valid while mem_req and mem_we.
REQ-010 SHALL have port mem_rdata  input  XLEN  read data; sampled on the edge where mem_ack=1.
REQ-011 SHALL have port mem_ack  input  1  transfer complete on any rising edge with mem_req=1 and mem_ack=1.
REQ-012 SHALL have port pc  output  XLEN  current program counter.
REQ-013 SHALL have port instr_retired  output  1  one-cycle pulse per completed instruction.
REQ-014 SHALL have port halted  output  1  core stopped on illegal instruction.

Function
REQ-015 SHALL be a multicycle core; states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, HALT.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on ack, IR<=mem_rdata[31:0], OLDPC<=PC, PC<=PC+4, go DECODE; otherwise stay.
REQ-017 DECODE: A<=reg[rs1], B<=reg[rs2], ALUOUT<=OLDPC+imm (B/J form per opcode); dispatch by opcode: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BEQ, 1101111 JAL.
REQ-018 MEMADR: ALUOUT<=A+imm (I form for lw, S form for sw); go MEMREAD for lw, MEMWRITE for sw.
REQ-019 MEMREAD: read request at ALUOUT; on ack, DATA<=mem_rdata, go MEMWB; MEMWB: rd<=DATA, go FETCH.
REQ-020 MEMWRITE: write request, mem_addr=ALUOUT, mem_wdata=B; on ack go FETCH.
REQ-021 EXECR/EXECI: ALUOUT<=A op B / A op imm; go ALUWB; ALUWB: rd<=ALUOUT, go FETCH.
REQ-022 ALU ops by funct3: 000 add (sub when R-type funct7=0100000), 010 signed set-less-than, 110 or, 111 and; results XLEN wide.
REQ-023 All immediates SHALL be sign-extended from bit 31 of IR to XLEN; arithmetic wraps modulo 2^XLEN.
REQ-024 BEQ: funct3=000; if A==B, PC<=ALUOUT; go FETCH.
REQ-025 JAL: rd<=OLDPC+4, PC<=ALUOUT; go FETCH.
REQ-026 Writes to register index 0 SHALL be discarded; reads of index 0 return 0.
REQ-027 Zero-wait latency (ack in first request cycle): beq 3, jal 3, sw 4, R/I 4, lw 5 cycles.
REQ-028 mem_addr/mem_we/mem_wdata SHALL remain stable from request assertion until ack; mem_req=0 in all non-memory states.
REQ-029 instr_retired SHALL pulse in the cycle after the last state of each instruction (first FETCH cycle following it).
REQ-030 Unsupported opcode/funct3 handling is set by Configuration.

Reset
REQ-031 On rst_n=0 asynchronously: state=FETCH, PC=RESET_PC, mem_req=0 (drop in-flight request), instr_retired=0, halted=0, IR/A/B/ALUOUT/DATA=0.
REQ-032 Register file contents SHALL be unaffected by reset except index 0 reads 0.
REQ-033 First request SHALL be issued in the first cycle after rst_n rises.

Configuration
REQ-034 Macro MC_ILLEGAL_TRAP_EN defined: unsupported instruction enters HALT from DECODE; HALT holds mem_req=0, halted=1, PC=OLDPC, no retire, exits only via reset.
REQ-035 Macro undefined: unsupported instruction treated as NOP, returns to FETCH from DECODE with instr_retired pulse; halted tied 0; no HALT state.

Verification
REQ-036 Reset, zero-wait mem with addi x1,x0,5 at 0 -> fetch addr 0, x1=5 after 4 cycles, pc=4, one retire pulse.
REQ-037 add/sub/slt: x1=-3, x2=2 -> add=-1, sub=-5, slt x3=1 (signed), or/and correct.
REQ-038 sw x1,8(x0) then lw x4,8(x0), ack delayed 3 cycles -> write addr 8 data x1, request stable during wait, x4=x1, lw 8 cycles.
REQ-039 beq x0,x0,-4 at 0x10 -> pc=0x0C after 3 cycles; jal x1,16 at 0x20 -> x1=0x24, pc=0x30.
REQ-040 rst_n low mid-FETCH wait -> mem_req drops same cycle, pc=RESET_PC; writes to x0 leave x0=0.
REQ-041 Opcode 0x0000007F: with MC_ILLEGAL_TRAP_EN halted=1, no further requests; without, pc advances by 4, retire pulses.
